// File: rtl/cosim_pkg.sv
// Shared co-simulation commit record types and sizing defaults.
// The record carries retired instructions, operand changes and trap info.
`ifndef COSIM_MAX_INSN
`define COSIM_MAX_INSN 4
`endif
`ifndef COSIM_MAX_OP
`define COSIM_MAX_OP 16
`endif

package cosim_pkg;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } cs_access_e;

    localparam logic [7:0] CAUSE_FAULT_LOAD = 8'd5;

    typedef struct packed {
        logic [1:0]  prv;
        logic [31:0] pc;
        logic [31:0] ir;
    } csChgInsn_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        cs_access_e  access;
        logic [7:0]  iNum;
    } csChgOP_t;

    typedef struct packed {
        logic        trp;
        logic        dbg;
        logic [7:0]  cause;
        logic [31:0] badaddr;
    } csTrapInfo_t;

    typedef struct packed {
        logic [7:0]                           iNum;
        logic [7:0]                           oNum;
        csChgInsn_t [`COSIM_MAX_INSN-1:0]     insn;
        csChgOP_t   [`COSIM_MAX_OP-1:0]       op;
        csTrapInfo_t                          ti;
    } csChgInfo_t;

endpackage

// File: rtl/cosim_rec_fifo.sv
// Record FIFO with two ordered push ports (port 0 lands first) and no bypass.
// Free space is checked per push; a pop in the same cycle frees a slot.
module cosim_rec_fifo #(
    parameter int  DEPTH = 8,
    parameter type rec_t = logic
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push0_i,
    input  rec_t       din0_i,
    input  logic       push1_i,
    input  rec_t       din1_i,
    input  logic       pop_i,
    output logic       valid_o,
    output logic       full_o,
    output rec_t       dout_o,
    output logic [1:0] drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] free;
    logic          pop, acc0, acc1;

    always_comb begin
        pop  = pop_i && (cnt_q != '0);
        free = DEPTH_C - cnt_q + CW'(pop);
        acc0 = push0_i && (free != '0);
        acc1 = push1_i && (free > CW'(acc0));
    end

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == DEPTH_C);
    assign dout_o  = valid_o ? mem_q[rd_q] : '0;
    assign drop_o  = {push1_i && !acc1, push0_i && !acc0};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(acc0) + AW'(acc1);
            rd_q  <= rd_q + AW'(pop);
            cnt_q <= cnt_q + CW'(acc0) + CW'(acc1) - CW'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; the zeroed count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (acc0) mem_q[wr_q] <= din0_i;
        if (acc1) mem_q[wr_q + AW'(acc0)] <= din1_i;
    end

endmodule

// File: rtl/cosim_commit_buf.sv
// Packs per-cycle retire lanes and operand changes into commit records,
// closing them on fill, trap or flush and queueing them for a consumer.
module cosim_commit_buf
    import cosim_pkg::*;
#(
    parameter int NRET     = 2,
    parameter int NOPS     = 2,
    parameter int MAX_INSN = `COSIM_MAX_INSN,
    parameter int MAX_OP   = `COSIM_MAX_OP,
    parameter int DEPTH    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic        [NRET-1:0]      ret_valid,
    input  csChgInsn_t  [NRET-1:0]      ret_insn,
    input  logic        [NOPS-1:0]      op_valid,
    input  csChgOP_t    [NOPS-1:0]      op_info,
    input  logic                        trap_valid,
    input  csTrapInfo_t                 trap_info,
    input  logic                        flush,
    output logic                        cm_ready,
    output logic                        rec_valid,
    input  logic                        rec_ready,
    output csChgInfo_t                  rec,
    output logic                        ovf,
    output logic        [15:0]          drop_cnt,
    output logic                        lane_err
);
    localparam logic [7:0] MAX_I = 8'(MAX_INSN);
    localparam logic [7:0] MAX_O = 8'(MAX_OP);
    localparam int IIW = $clog2(`COSIM_MAX_INSN);
    localparam int OIW = $clog2(`COSIM_MAX_OP);

    csChgInfo_t  open_q, open_d, work, pre_rec, post_rec;
    csChgOP_t    opd;
    logic [7:0]  icnt_q, icnt_d, ocnt_q, ocnt_d;
    logic [7:0]  n_acc, m_ops, ib, ob, k, new_i, new_o;
    logic        gap, lane_bad, pre_close, post_close, post_push;
    logic        ovf_q, lane_err_q, fifo_full;
    logic [15:0] drop_q;
    logic [1:0]  drops;
    logic [16:0] drop_sum;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        n_acc    = '0;
        gap      = 1'b0;
        lane_bad = 1'b0;
        for (int i = 0; i < NRET; i++) begin
            if (!ret_valid[i])  gap = 1'b1;
            else if (gap)       lane_bad = 1'b1;
            else                n_acc = n_acc + 8'd1;
        end
        m_ops = '0;
        for (int p = 0; p < NOPS; p++) m_ops = m_ops + 8'(op_valid[p]);

        pre_close = (icnt_q != '0) &&
                    ((icnt_q + n_acc > MAX_I) || (ocnt_q + m_ops > MAX_O));
        pre_rec      = open_q;
        pre_rec.iNum = icnt_q;
        pre_rec.oNum = ocnt_q;

        // The open record never carries trap info; ti is attached only at close.
        work = pre_close ? '0 : open_q;
        ib   = pre_close ? '0 : icnt_q;
        ob   = pre_close ? '0 : ocnt_q;
        for (int j = 0; j < NRET; j++) begin
            if ((8'(j) < n_acc) && (ib + 8'(j) < MAX_I))
                work.insn[IIW'(ib + 8'(j))] = ret_insn[j];
        end
        k   = '0;
        opd = '0;
        for (int p = 0; p < NOPS; p++) begin
            if (op_valid[p]) begin
                opd      = op_info[p];
                opd.iNum = ib + op_info[p].iNum;
                if (ob + k < MAX_O) work.op[OIW'(ob + k)] = opd;
                k = k + 8'd1;
            end
        end
        new_i = ib + n_acc;
        new_o = (ob + m_ops > MAX_O) ? MAX_O : ob + m_ops;

        post_close    = (new_i >= MAX_I) || trap_valid || flush;
        post_push     = post_close && ((new_i != '0) || trap_valid);
        post_rec      = work;
        post_rec.iNum = new_i;
        post_rec.oNum = new_o;
        post_rec.ti   = trap_valid ? trap_info : '0;

        open_d = post_close ? '0 : work;
        icnt_d = post_close ? '0 : new_i;
        ocnt_d = post_close ? '0 : new_o;

        drop_sum = {1'b0, drop_q} + 17'(drops[0]) + 17'(drops[1]);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            open_q     <= '0;
            icnt_q     <= '0;
            ocnt_q     <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
            lane_err_q <= 1'b0;
        end else begin
            open_q     <= open_d;
            icnt_q     <= icnt_d;
            ocnt_q     <= ocnt_d;
            lane_err_q <= lane_err_q | lane_bad;
            if (drops != 2'b00) begin
                ovf_q  <= 1'b1;
                drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    cosim_rec_fifo #(
        .DEPTH (DEPTH),
        .rec_t (csChgInfo_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0_i (pre_close),
        .din0_i  (pre_rec),
        .push1_i (post_push),
        .din1_i  (post_rec),
        .pop_i   (rec_valid && rec_ready),
        .valid_o (rec_valid),
        .full_o  (fifo_full),
        .dout_o  (rec),
        .drop_o  (drops)
    );

    assign cm_ready = !fifo_full;
    assign ovf      = ovf_q;
    assign drop_cnt = drop_q;
    assign lane_err = lane_err_q;

endmodule
